// File: rtl/lutram_fifo128.sv
// 128-entry first-word-fall-through FIFO built from RAM128X1D distributed RAM, one primitive per data bit.
// Optional: define LUTRAM_FIFO_ALMOST_FULL_EN to add the ALMOST_FULL_THRESH parameter and a registered almost_full output.

module lutram_fifo128 #(
    parameter int WIDTH = 8
`ifdef LUTRAM_FIFO_ALMOST_FULL_EN
    ,
    parameter int ALMOST_FULL_THRESH = 120
`endif
) (
    input  logic             CLK,
    input  logic             reset,
    input  logic [WIDTH-1:0] process_input,
    input  logic             valid_in,
    output logic             ready,
    output logic [WIDTH-1:0] process_output,
    output logic             valid_out,
    input  logic             ready_downstream,
`ifdef LUTRAM_FIFO_ALMOST_FULL_EN
    output logic             almost_full,
`endif
    output logic [7:0]       count
);

    logic [6:0]       wr_ptr;
    logic [6:0]       rd_ptr;
    logic [7:0]       cnt;
    logic [7:0]       cnt_next;
    logic             push;
    logic             pop;
    logic             we;
    logic [WIDTH-1:0] spo_unused;

    // Flags depend on registered state only, so no input reaches ready or valid_out.
    assign ready     = (cnt != 8'd128);
    assign valid_out = (cnt != 8'd0);
    assign count     = cnt;
    assign push      = valid_in & ready;
    assign pop       = valid_out & ready_downstream;
    assign we        = push & ~reset;

    // NOTE: every variable assigned in always_comb gets a default first, so no latch is inferred.
    always_comb begin
        cnt_next = cnt;
        case ({push, pop})
            2'b10:   cnt_next = cnt + 8'd1;
            2'b01:   cnt_next = cnt - 8'd1;
            default: cnt_next = cnt;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together at the edge.
    always_ff @(posedge CLK or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 7'd1;
            if (pop)  rd_ptr <= rd_ptr + 7'd1;
            cnt <= cnt_next;
        end
    end

`ifdef LUTRAM_FIFO_ALMOST_FULL_EN
    always_ff @(posedge CLK or posedge reset) begin
        if (reset) almost_full <= 1'b0;
        else        almost_full <= (32'(cnt_next) >= ALMOST_FULL_THRESH);
    end
`endif

    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        RAM128X1D #(
            .INIT(128'h0)
        ) u_ram (
            .WCLK(CLK),
            .WE  (we),
            .A   (wr_ptr),
            .D   (process_input[i]),
            .SPO (spo_unused[i]),
            .DPRA(rd_ptr),
            .DPO (process_output[i])
        );
    end

endmodule

// Behavioural model of the 128x1 dual-port distributed RAM primitive: synchronous write, asynchronous reads.
module RAM128X1D #(
    parameter logic [127:0] INIT = 128'h0
) (
    input  logic       WCLK,
    input  logic       WE,
    input  logic [6:0] A,
    input  logic       D,
    output logic       SPO,
    input  logic [6:0] DPRA,
    output logic       DPO
);

    logic mem [0:127];

    // NOTE: the storage array has no reset; contents only change through the write port.
    always_ff @(posedge WCLK) begin
        if (WE) mem[A] <= D;
    end

    assign SPO = mem[A];
    assign DPO = mem[DPRA];

endmodule

// File: tb/tb_lutram_fifo128.sv
// Scoreboard bench for lutram_fifo128; also checks almost_full when LUTRAM_FIFO_ALMOST_FULL_EN is defined.

module tb_lutram_fifo128;

    localparam int WIDTH = 8;
    localparam int DEPTH = 128;
`ifdef LUTRAM_FIFO_ALMOST_FULL_EN
    localparam int THRESH = 120;
`endif

    logic             CLK;
    logic             reset;
    logic [WIDTH-1:0] process_input;
    logic             valid_in;
    logic             ready;
    logic [WIDTH-1:0] process_output;
    logic             valid_out;
    logic             ready_downstream;
    logic [7:0]       count;
`ifdef LUTRAM_FIFO_ALMOST_FULL_EN
    logic             almost_full;
`endif

    lutram_fifo128 #(
        .WIDTH(WIDTH)
`ifdef LUTRAM_FIFO_ALMOST_FULL_EN
        ,
        .ALMOST_FULL_THRESH(THRESH)
`endif
    ) dut (
        .CLK             (CLK),
        .reset           (reset),
        .process_input   (process_input),
        .valid_in        (valid_in),
        .ready           (ready),
        .process_output  (process_output),
        .valid_out       (valid_out),
        .ready_downstream(ready_downstream),
`ifdef LUTRAM_FIFO_ALMOST_FULL_EN
        .almost_full     (almost_full),
`endif
        .count           (count)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    int n_checks = 0;
    int n_errors = 0;
    logic [WIDTH-1:0] sb_q[$];
    int n_sent;
    int n_recv;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Inputs are already driven; check flags and head data on the falling edge,
    // update the scoreboard with what the rising edge will do, then step past it.
    task automatic cycle();
        logic do_pop;
        logic do_push;
        @(negedge CLK);
        check("count", 32'(count), 32'(sb_q.size()));
        check("ready", 32'(ready), 32'(sb_q.size() != DEPTH));
        check("valid_out", 32'(valid_out), 32'(sb_q.size() != 0));
        do_pop  = (sb_q.size() != 0) && ready_downstream;
        do_push = (sb_q.size() != DEPTH) && valid_in;
        if (do_pop) begin
            check("head_data", 32'(process_output), 32'(sb_q[0]));
            void'(sb_q.pop_front());
            n_recv++;
        end
        if (do_push) begin
            sb_q.push_back(process_input);
            n_sent++;
        end
        @(posedge CLK);
        #1;
`ifdef LUTRAM_FIFO_ALMOST_FULL_EN
        check("almost_full", 32'(almost_full), 32'(sb_q.size() >= THRESH));
`endif
    endtask

    task automatic drain(input int budget);
        int k;
        valid_in         = 1'b0;
        ready_downstream = 1'b1;
        k = 0;
        while (sb_q.size() != 0 && k < budget) begin
            cycle();
            k++;
        end
        if (sb_q.size() != 0) check("drain_timeout", 32'(sb_q.size()), 32'd0);
        ready_downstream = 1'b0;
        cycle();
    endtask

    initial begin
        int k;
        reset            = 1'b1;
        process_input    = '0;
        valid_in         = 1'b0;
        ready_downstream = 1'b0;
        n_sent           = 0;
        n_recv           = 0;

        #1;
        check("rst_ready", 32'(ready), 32'd1);
        check("rst_valid", 32'(valid_out), 32'd0);
        check("rst_count", 32'(count), 32'd0);
        @(posedge CLK);
        #1;
        reset = 1'b0;

        // Idle after reset.
        for (int i = 0; i < 10; i++) cycle();

        // Reset pulse with valid_in high must not write anything.
        valid_in      = 1'b1;
        process_input = 8'h77;
        reset         = 1'b1;
        @(posedge CLK);
        #1;
        check("rst_pulse_count", 32'(count), 32'd0);
        valid_in = 1'b0;
        reset    = 1'b0;
        cycle();

        // Single word.
        valid_in      = 1'b1;
        process_input = 8'hA5;
        cycle();
        valid_in = 1'b0;
        cycle();
        check("single_data", 32'(process_output), 32'hA5);
        check("single_count", 32'(count), 32'd1);
        ready_downstream = 1'b1;
        cycle();
        ready_downstream = 1'b0;
        cycle();
        check("single_empty", 32'(valid_out), 32'd0);

        // Fill with 0x00..0x7F.
        for (int i = 0; i < DEPTH; i++) begin
            valid_in      = 1'b1;
            process_input = 8'(i);
            cycle();
        end
        check("full_count", 32'(count), 32'd128);
        check("full_ready", 32'(ready), 32'd0);

        // Extra word offered while full is dropped.
        process_input = 8'hFF;
        cycle();
        check("full_hold_count", 32'(count), 32'd128);

        // Push and pop offered together at full: only the pop happens, then both.
        process_input    = 8'h80;
        ready_downstream = 1'b1;
        cycle();
        check("full_pop_count", 32'(count), 32'd127);
        process_input = 8'h81;
        cycle();
        process_input = 8'h82;
        cycle();
        check("both_count", 32'(count), 32'd127);
        drain(400);
        check("drain_empty", 32'(valid_out), 32'd0);

        // Random streaming of 300 words across the pointer wrap.
        n_sent = 0;
        n_recv = 0;
        k = 0;
        while ((n_sent < 300 || n_recv < n_sent) && k < 5000) begin
            valid_in         = (n_sent < 300) ? 1'($urandom_range(0, 1)) : 1'b0;
            process_input    = 8'($urandom());
            ready_downstream = 1'($urandom_range(0, 1));
            cycle();
            if (count > 8'd128) check("count_bound", 32'(count), 32'd128);
            k++;
        end
        check("stream_sent", 32'(n_sent), 32'd300);
        check("stream_recv", 32'(n_recv), 32'd300);
        ready_downstream = 1'b0;

        // Reset in the middle of a stream at count=50.
        for (int i = 0; i < 50; i++) begin
            valid_in      = 1'b1;
            process_input = 8'(i + 8'h40);
            cycle();
        end
        valid_in = 1'b0;
        check("pre_rst_count", 32'(count), 32'd50);
        reset = 1'b1;
        #1;
        check("async_rst_count", 32'(count), 32'd0);
        check("async_rst_valid", 32'(valid_out), 32'd0);
        sb_q.delete();
        @(posedge CLK);
        #1;
        reset = 1'b0;
        valid_in      = 1'b1;
        process_input = 8'h3C;
        cycle();
        valid_in = 1'b0;
        cycle();
        check("post_rst_data", 32'(process_output), 32'h3C);
        drain(10);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
